parallel_nibble_receiver: RTL and testbench

Receiving end of the 4-bit parallel register-transfer link. It samples nibbles arriving from the two-stage transfer chain and reassembles them, LSB nibble first, into 16-bit words. Completed words are buffered in a small FIFO and presented downstream on a valid/ready handshake. It sits between the parallel link output and any word-wide consumer, such as a display or checksum stage.

---
 rtl/pnr_pkg.sv | 18 +
 rtl/parallel_nibble_receiver_if.sv | 39 +++
 rtl/pnr_word_fifo.sv | 57 +++++
 rtl/parallel_nibble_receiver.sv | 126 ++++++++++++
 tb/tb_parallel_nibble_receiver.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/pnr_pkg.sv
// pnr_pkg: shared definitions for the parallel nibble receiver.
//   NIBBLE_W      : width of one link nibble (4).
//   pnr_state_t   : assembly FSM state, IDLE = 1'b0, COLLECT = 1'b1.
//   pnr_word_w()  : word width derived from the nibble count.
package pnr_pkg;

   localparam int NIBBLE_W = 4;

   typedef logic [0:0] pnr_state_t;

   localparam pnr_state_t ST_IDLE    = 1'b0;  // count == 0
   localparam pnr_state_t ST_COLLECT = 1'b1;  // 1 <= count <= NIBBLES-1

   function automatic int pnr_word_w(input int nibbles);
      return NIBBLE_W * nibbles;
   endfunction

endpackage

// File: rtl/parallel_nibble_receiver_if.sv
// parallel_nibble_receiver_if: link-side nibble inputs and word-side
// valid/ready stream of the receiver.
//   data_in/in_valid/in_sof : nibble link (no backpressure)
//   in_par                  : even parity for data_in (PNR_PARITY_EN only)
//   out_data/out_valid      : head-of-FIFO word stream
//   out_ready               : consumer accept
// Modports: master = link source + word consumer, slave = the receiver.
// Optional macro: PNR_PARITY_EN adds in_par.
interface parallel_nibble_receiver_if #(parameter int W = 16);

   logic [3:0]   data_in;
   logic         in_valid;
   logic         in_sof;
`ifdef PNR_PARITY_EN
   logic         in_par;
`endif
   logic [W-1:0] out_data;
   logic         out_valid;
   logic         out_ready;

   modport master (
      output data_in, in_valid, in_sof,
`ifdef PNR_PARITY_EN
      output in_par,
`endif
      output out_ready,
      input  out_data, out_valid
   );

   modport slave (
      input  data_in, in_valid, in_sof,
`ifdef PNR_PARITY_EN
      input  in_par,
`endif
      input  out_ready,
      output out_data, out_valid
   );

endinterface

// File: rtl/pnr_word_fifo.sv
// pnr_word_fifo: small synchronous word FIFO.
//   clk, reset            : clock, synchronous active-high reset
//   push/push_data/full   : write side; a push while full is dropped unless
//                           a pop happens on the same edge
//   pop/head/empty        : read side; pop while empty is ignored
//   level                 : occupancy, from pointers carrying one extra bit
module pnr_word_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   output logic                     full,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
   logic             push_ok, pop_ok;

   always_comb begin
      level   = wr_q - rd_q;
      full    = (level == (AW+1)'(DEPTH));
      empty   = (level == '0);
      pop_ok  = pop && !empty;
      // A pop on the same edge frees the slot the push needs.
      push_ok = push && (!full || pop_ok);
      head    = mem_q[rd_q[AW-1:0]];

      mem_d = mem_q;
      if (push_ok) mem_d[wr_q[AW-1:0]] = push_data;
      wr_d = wr_q + (AW+1)'(push_ok);
      rd_d = rd_q + (AW+1)'(pop_ok);
   end

   // Storage is cleared too so head reads 0 straight out of reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_q <= '0;
         rd_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         mem_q <= mem_d;
      end
   end

endmodule

// File: rtl/parallel_nibble_receiver.sv
// parallel_nibble_receiver: reassembles 4-bit link nibbles, LSB nibble
// first, into W = 4*NIBBLES bit words and buffers them in a DEPTH-entry FIFO
// presented on a valid/ready stream.
//   clk, reset : clock, synchronous active-high reset
//   link       : slave side of parallel_nibble_receiver_if (nibbles in,
//                words out)
//   level      : FIFO occupancy
//   overflow   : sticky, completed word dropped on a full FIFO
//   sync_err   : sticky, in_sof seen while a partial word was held
//   par_err    : sticky parity failure (PNR_PARITY_EN only)
// Optional macro: PNR_PARITY_EN adds the in_par check and par_err.
module parallel_nibble_receiver
   import pnr_pkg::*;
#(
   parameter int NIBBLES = 4,
   parameter int DEPTH   = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   parallel_nibble_receiver_if.slave link,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow,
`ifdef PNR_PARITY_EN
   output logic                     par_err,
`endif
   output logic                     sync_err
);

   localparam int W  = pnr_word_w(NIBBLES);
   localparam int CW = $clog2(NIBBLES) + 1;

   pnr_state_t     state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [W-1:0]   word_q, word_d;
   logic           overflow_q, overflow_d;
   logic           sync_err_q, sync_err_d;
   logic           push;
   logic           fifo_full, fifo_empty, pop_ok;

   assign pop_ok = link.out_ready && !fifo_empty;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      word_d     = word_q;
      sync_err_d = sync_err_q;
      push       = 1'b0;

      if (link.in_valid) begin
         if (state_q == ST_IDLE || link.in_sof) begin
            // Fresh word: a sof mid-word throws the partial word away.
            if (state_q == ST_COLLECT) sync_err_d = 1'b1;
            word_d              = '0;
            word_d[NIBBLE_W-1:0] = link.data_in;
            if (NIBBLES == 1) begin
               push    = 1'b1;
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               state_d = ST_COLLECT;
               cnt_d   = CW'(1);
            end
         end else begin
            for (int i = 1; i < NIBBLES; i++)
               if (cnt_q == CW'(i)) word_d[i*NIBBLE_W +: NIBBLE_W] = link.data_in;
            if (cnt_q == CW'(NIBBLES-1)) begin
               push    = 1'b1;
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d   = cnt_q + CW'(1);
            end
         end
      end

      overflow_d = overflow_q | (push && fifo_full && !pop_ok);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         word_q     <= '0;
         overflow_q <= 1'b0;
         sync_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         word_q     <= word_d;
         overflow_q <= overflow_d;
         sync_err_q <= sync_err_d;
      end
   end

`ifdef PNR_PARITY_EN
   logic par_err_q, par_err_d;

   // Even parity across nibble + parity bit; the nibble is kept regardless.
   always_comb par_err_d = par_err_q | (link.in_valid && ^{link.data_in, link.in_par});

   always_ff @(posedge clk) begin
      if (reset) par_err_q <= 1'b0;
      else       par_err_q <= par_err_d;
   end

   assign par_err = par_err_q;
`endif

   // The word is pushed on the edge that captures its last nibble.
   pnr_word_fifo #(.WIDTH(W), .DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (word_d),
      .full      (fifo_full),
      .pop       (link.out_ready),
      .head      (link.out_data),
      .empty     (fifo_empty),
      .level     (level)
   );

   assign link.out_valid = !fifo_empty;
   assign overflow       = overflow_q;
   assign sync_err       = sync_err_q;

endmodule

// File: tb/tb_parallel_nibble_receiver.sv
module tb_parallel_nibble_receiver;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] level;
   logic       overflow, sync_err;
`ifdef PNR_PARITY_EN
   logic       par_err;
`endif
   int checks   = 0;
   int failures = 0;

   parallel_nibble_receiver_if #(.W(16)) link ();

   parallel_nibble_receiver #(.NIBBLES(4), .DEPTH(2)) dut (
      .clk      (clk),
      .reset    (reset),
      .link     (link.slave),
      .level    (level),
      .overflow (overflow),
`ifdef PNR_PARITY_EN
      .par_err  (par_err),
`endif
      .sync_err (sync_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_nib(input logic [3:0] d, input logic sof);
      link.data_in  = d;
      link.in_valid = 1'b1;
      link.in_sof   = sof;
`ifdef PNR_PARITY_EN
      link.in_par   = ^d;
`endif
   endtask

   task automatic send(input logic [3:0] d, input logic sof);
      set_nib(d, sof);
      tick();
      link.in_valid = 1'b0;
      link.in_sof   = 1'b0;
   endtask

   task automatic send_word(input logic [15:0] w);
      for (int i = 0; i < 4; i++) send(w[i*4 +: 4], i == 0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      link.in_valid = 1'b0;
      link.in_sof = 1'b0;
      link.out_ready = 1'b0;
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks += 5;
      if (link.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", link.out_valid); end
      if (link.out_data !== 16'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=0000", link.out_data); end
      if (level !== 2'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
      if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
      if (sync_err !== 1'b0) begin failures++; $display("FAIL reset_sync_err got=%b exp=0", sync_err); end
   endtask

   task automatic test_basic();
      do_reset();
      link.out_ready = 1'b1;
      send(4'h1, 1'b1); send(4'h2, 1'b0); send(4'h3, 1'b0);
      checks++;
      if (link.out_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid got=%b exp=0", link.out_valid); end
      send(4'h4, 1'b0);
      checks += 2;
      if (link.out_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", link.out_valid); end
      if (link.out_data !== 16'h4321) begin failures++; $display("FAIL basic_data got=%h exp=4321", link.out_data); end
      tick();
      checks++;
      if (link.out_valid !== 1'b0) begin failures++; $display("FAIL basic_one_cycle got=%b exp=0", link.out_valid); end
   endtask

   task automatic test_gapped();
      do_reset();
      send(4'hA, 1'b1); tick();
      send(4'hB, 1'b0); tick(); tick();
      send(4'hC, 1'b0);
      checks++;
      if (link.out_valid !== 1'b0) begin failures++; $display("FAIL gap_early_valid got=%b exp=0", link.out_valid); end
      send(4'hD, 1'b0);
      checks += 3;
      if (link.out_data !== 16'hDCBA) begin failures++; $display("FAIL gap_data got=%h exp=dcba", link.out_data); end
      if (level !== 2'd1) begin failures++; $display("FAIL gap_level got=%0d exp=1", level); end
      if (sync_err !== 1'b0) begin failures++; $display("FAIL gap_sync_err got=%b exp=0", sync_err); end
   endtask

   task automatic test_resync();
      do_reset();
      send(4'h5, 1'b1); send(4'h6, 1'b0);
      send(4'h1, 1'b1); send(4'h2, 1'b0); send(4'h3, 1'b0); send(4'h4, 1'b0);
      checks += 3;
      if (sync_err !== 1'b1) begin failures++; $display("FAIL resync_sync_err got=%b exp=1", sync_err); end
      if (level !== 2'd1) begin failures++; $display("FAIL resync_level got=%0d exp=1", level); end
      if (link.out_data !== 16'h4321) begin failures++; $display("FAIL resync_data got=%h exp=4321", link.out_data); end
   endtask

   task automatic test_overflow();
      do_reset();
      send_word(16'h1111); send_word(16'h2222); send_word(16'h3333);
      checks += 3;
      if (level !== 2'd2) begin failures++; $display("FAIL ovf_level got=%0d exp=2", level); end
      if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
      if (link.out_data !== 16'h1111) begin failures++; $display("FAIL ovf_head0 got=%h exp=1111", link.out_data); end
      link.out_ready = 1'b1;
      tick();
      checks += 2;
      if (link.out_data !== 16'h2222) begin failures++; $display("FAIL ovf_head1 got=%h exp=2222", link.out_data); end
      if (level !== 2'd1) begin failures++; $display("FAIL ovf_level1 got=%0d exp=1", level); end
      tick();
      checks++;
      if (level !== 2'd0) begin failures++; $display("FAIL ovf_drained got=%0d exp=0", level); end
   endtask

   task automatic test_full_pop();
      do_reset();
      send_word(16'h1111); send_word(16'h2222);
      send(4'h3, 1'b1); send(4'h3, 1'b0); send(4'h3, 1'b0);
      link.out_ready = 1'b1;
      send(4'h3, 1'b0);
      link.out_ready = 1'b0;
      checks += 3;
      if (overflow !== 1'b0) begin failures++; $display("FAIL fullpop_overflow got=%b exp=0", overflow); end
      if (level !== 2'd2) begin failures++; $display("FAIL fullpop_level got=%0d exp=2", level); end
      if (link.out_data !== 16'h2222) begin failures++; $display("FAIL fullpop_head0 got=%h exp=2222", link.out_data); end
      link.out_ready = 1'b1;
      tick();
      checks += 2;
      if (link.out_data !== 16'h3333) begin failures++; $display("FAIL fullpop_head1 got=%h exp=3333", link.out_data); end
      if (level !== 2'd1) begin failures++; $display("FAIL fullpop_level1 got=%0d exp=1", level); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      send_word(16'h8765);
      send(4'h7, 1'b1); send(4'h8, 1'b0);
      do_reset();
      checks += 2;
      if (level !== 2'd0) begin failures++; $display("FAIL rstmid_level got=%0d exp=0", level); end
      if (link.out_data !== 16'h0) begin failures++; $display("FAIL rstmid_data got=%h exp=0000", link.out_data); end
      // No sof on the first nibble: IDLE accepts it anyway.
      send(4'h1, 1'b0); send(4'h2, 1'b0); send(4'h3, 1'b0); send(4'h4, 1'b0);
      checks += 3;
      if (link.out_data !== 16'h4321) begin failures++; $display("FAIL rstmid_word got=%h exp=4321", link.out_data); end
      if (level !== 2'd1) begin failures++; $display("FAIL rstmid_level1 got=%0d exp=1", level); end
      if (sync_err !== 1'b0) begin failures++; $display("FAIL rstmid_sync_err got=%b exp=0", sync_err); end
   endtask

`ifdef PNR_PARITY_EN
   task automatic test_parity();
      do_reset();
      send(4'h3, 1'b1);
      checks++;
      if (par_err !== 1'b0) begin failures++; $display("FAIL par_good got=%b exp=0", par_err); end
      set_nib(4'h3, 1'b0);
      link.in_par = 1'b1;
      tick();
      link.in_valid = 1'b0;
      checks++;
      if (par_err !== 1'b1) begin failures++; $display("FAIL par_bad got=%b exp=1", par_err); end
   endtask
`endif

   initial begin
      reset = 1'b1;
      link.data_in = '0;
      link.in_valid = 1'b0;
      link.in_sof = 1'b0;
      link.out_ready = 1'b0;
`ifdef PNR_PARITY_EN
      link.in_par = 1'b0;
`endif
      test_reset();
      test_basic();
      test_gapped();
      test_resync();
      test_overflow();
      test_full_pop();
      test_reset_mid();
`ifdef PNR_PARITY_EN
      test_parity();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
